// File: rtl/pipelined_add_sub.sv
// Pipelined two's-complement adder/subtracter with carry-in, flags and
// a valid/ready handshake; the carry chain is cut into STAGES chunks.
//
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   in_valid / in_ready   operand handshake (in_ready = pipeline advance)
//   A, B                  WIDTH-bit operands
//   op                    00 add, 01 sub, 10 adc, 11 sbc
//   cin                   carry / not-borrow in for adc and sbc
//   out_valid / out_ready result handshake
//   Sum                   WIDTH-bit result, modulo 2^WIDTH
//   Cout, V, Z, N         carry (1 = no borrow on subtract), overflow,
//                         zero, negative
module pipelined_add_sub #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [1:0]       op,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Sum,
   output logic             Cout,
   output logic             V,
   output logic             Z,
   output logic             N
);

   localparam int CW = WIDTH / STAGES;
   localparam int L  = STAGES - 1;

   // Per-stage registers: operands travel alongside the partial sum.
   logic             r_vld [STAGES];
   logic [WIDTH-1:0] r_a   [STAGES];
   logic [WIDTH-1:0] r_b   [STAGES];
   logic [WIDTH-1:0] r_s   [STAGES];
   logic             r_c   [STAGES];
   logic             r_v;
   logic             r_z;
   logic             r_n;

   // Sources feeding each stage and the values it will register.
   logic             w_adv;
   logic [WIDTH-1:0] w_b;
   logic             w_c0;
   logic             w_sv  [STAGES];
   logic [WIDTH-1:0] w_sa  [STAGES];
   logic [WIDTH-1:0] w_sb  [STAGES];
   logic [WIDTH-1:0] w_ss  [STAGES];
   logic             w_sc  [STAGES];
   logic [CW:0]      w_chk [STAGES];
   logic [WIDTH-1:0] w_ns  [STAGES];
   logic             w_nc  [STAGES];
   logic             w_v;
   logic             w_z;
   logic             w_n;

   // A stalled full output freezes the whole pipe; bubbles are kept.
   assign w_adv     = out_ready | ~r_vld[L];
   assign in_ready  = w_adv;
   assign out_valid = r_vld[L];
   assign Sum       = r_s[L];
   assign Cout      = r_c[L];
   assign V         = r_v;
   assign Z         = r_z;
   assign N         = r_n;

   always_comb begin
      // Subtract is A + ~B + 1; sbc uses cin directly as not-borrow.
      w_b  = B ^ {WIDTH{op[0]}};
      w_c0 = op[1] ? cin : op[0];

      w_sv[0] = in_valid;
      w_sa[0] = A;
      w_sb[0] = w_b;
      w_ss[0] = '0;
      w_sc[0] = w_c0;
      for (int k = 1; k < STAGES; k++) begin
         w_sv[k] = r_vld[k-1];
         w_sa[k] = r_a[k-1];
         w_sb[k] = r_b[k-1];
         w_ss[k] = r_s[k-1];
         w_sc[k] = r_c[k-1];
      end

      for (int k = 0; k < STAGES; k++) begin
         w_chk[k] = {1'b0, w_sa[k][k*CW +: CW]}
                  + {1'b0, w_sb[k][k*CW +: CW]}
                  + {{CW{1'b0}}, w_sc[k]};
         w_ns[k]  = w_ss[k];
         w_ns[k][k*CW +: CW] = w_chk[k][CW-1:0];
         w_nc[k]  = w_chk[k][CW];
      end

      // Carry into the MSB is recovered from the MSB sum bit.
      w_v = (w_sa[L][WIDTH-1] ^ w_sb[L][WIDTH-1] ^ w_ns[L][WIDTH-1])
          ^ w_nc[L];
      w_z = ~|w_ns[L];
      w_n = w_ns[L][WIDTH-1];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < STAGES; k++) begin
            r_vld[k] <= 1'b0;
            r_a[k]   <= '0;
            r_b[k]   <= '0;
            r_s[k]   <= '0;
            r_c[k]   <= 1'b0;
         end
         r_v <= 1'b0;
         r_z <= 1'b0;
         r_n <= 1'b0;
      end else if (w_adv) begin
         for (int k = 0; k < STAGES; k++) begin
            r_vld[k] <= w_sv[k];
            // Data only moves with a valid op, so idle inputs never
            // disturb the held result.
            if (w_sv[k]) begin
               r_a[k] <= w_sa[k];
               r_b[k] <= w_sb[k];
               r_s[k] <= w_ns[k];
               r_c[k] <= w_nc[k];
            end
         end
         if (w_sv[L]) begin
            r_v <= w_v;
            r_z <= w_z;
            r_n <= w_n;
         end
      end
   end

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Randomised bench for pipelined_add_sub against an arithmetic model,
// covering 32-bit/4-stage, 64-bit/1-stage and 64-bit/8-stage builds.
module tb_pipelined_add_sub;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        in_valid;
   logic        out_ready;
   logic        cin;
   logic [1:0]  op;
   logic [63:0] A;
   logic [63:0] B;
   int          sel;
   int          cur_w;
   int          cur_s;

   int n_chk = 0;
   int n_err = 0;

   logic [2:0]  iv, ir, ov, co, vv, zz, nn;
   logic [31:0] s32;
   logic [63:0] s64a, s64b;

   assign iv[0] = in_valid && (sel == 0);
   assign iv[1] = in_valid && (sel == 1);
   assign iv[2] = in_valid && (sel == 2);

   pipelined_add_sub #(.WIDTH(32), .STAGES(4)) u_w32s4 (
      .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
      .A(A[31:0]), .B(B[31:0]), .op(op), .cin(cin),
      .out_valid(ov[0]), .out_ready(out_ready), .Sum(s32),
      .Cout(co[0]), .V(vv[0]), .Z(zz[0]), .N(nn[0]));

   pipelined_add_sub #(.WIDTH(64), .STAGES(1)) u_w64s1 (
      .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
      .A(A), .B(B), .op(op), .cin(cin),
      .out_valid(ov[1]), .out_ready(out_ready), .Sum(s64a),
      .Cout(co[1]), .V(vv[1]), .Z(zz[1]), .N(nn[1]));

   pipelined_add_sub #(.WIDTH(64), .STAGES(8)) u_w64s8 (
      .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
      .A(A), .B(B), .op(op), .cin(cin),
      .out_valid(ov[2]), .out_ready(out_ready), .Sum(s64b),
      .Cout(co[2]), .V(vv[2]), .Z(zz[2]), .N(nn[2]));

   logic        m_ir, m_ov, m_c, m_v, m_z, m_n;
   logic [63:0] m_sum;

   always_comb begin
      m_ir  = ir[sel];
      m_ov  = ov[sel];
      m_c   = co[sel];
      m_v   = vv[sel];
      m_z   = zz[sel];
      m_n   = nn[sel];
      m_sum = (sel == 0) ? {32'b0, s32} : (sel == 1) ? s64a : s64b;
   end

   typedef struct {
      logic [63:0] sum;
      logic        c;
      logic        v;
      logic        z;
      logic        n;
   } res_t;

   res_t q[$];

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h (w=%0d s=%0d t=%0t)",
                  tag, got, exp, cur_w, cur_s, $time);
      end
   endtask

   // Plain integer arithmetic: unsigned for carry, signed for overflow.
   function automatic res_t model(input logic [63:0] a, input logic [63:0] b,
                                  input logic [1:0] o, input logic ci,
                                  input int w);
      res_t r;
      logic [127:0]        mask, ua, ub, full, pw;
      logic signed [127:0] lim, sa, sb, sr;
      logic                bor;
      pw   = 128'd1 << w;
      mask = pw - 128'd1;
      ua   = {64'b0, a} & mask;
      ub   = {64'b0, b} & mask;
      lim  = 128'sd1 <<< (w - 1);
      sa   = $signed(ua);
      sb   = $signed(ub);
      if (ua[w-1]) sa = sa - $signed(pw);
      if (ub[w-1]) sb = sb - $signed(pw);
      bor  = 1'b0;
      case (o)
         2'b00: begin full = ua + ub;            sr = sa + sb; end
         2'b10: begin full = ua + ub + ci;       sr = sa + sb + ci; end
         2'b01: begin full = ua + pw - ub;       sr = sa - sb; end
         default: begin
            bor  = ~ci;
            full = ua + pw - ub - bor;
            sr   = sa - sb - bor;
         end
      endcase
      if (o[0]) r.c = (ua >= ub + bor);
      else      r.c = (full >= pw);
      full  = full & mask;
      r.sum = full[63:0];
      r.v   = (sr >= lim) || (sr < -lim);
      r.z   = (full == 128'd0);
      r.n   = full[w-1];
      return r;
   endfunction

   function automatic logic [63:0] rnd_op();
      logic [63:0] x;
      logic [127:0] m;
      m = (128'd1 << cur_w) - 128'd1;
      case ($urandom_range(0, 5))
         0:       x = '0;
         1:       x = '1;
         2:       x = 64'd1 << (cur_w - 1);
         default: x = {$urandom, $urandom};
      endcase
      x = x & m[63:0];
      return x;
   endfunction

   task automatic check_outs(input string tag, input res_t e);
      chk({tag, "_sum"}, m_sum, e.sum);
      chk({tag, "_cout"}, {63'b0, m_c}, {63'b0, e.c});
      chk({tag, "_v"}, {63'b0, m_v}, {63'b0, e.v});
      chk({tag, "_z"}, {63'b0, m_z}, {63'b0, e.z});
      chk({tag, "_n"}, {63'b0, m_n}, {63'b0, e.n});
   endtask

   task automatic reset_dut();
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_ovalid", {63'b0, m_ov}, 64'd0);
      chk("rst_iready", {63'b0, m_ir}, 64'd1);
      chk("rst_sum", m_sum, 64'd0);
      chk("rst_flags", {60'b0, m_c, m_v, m_z, m_n}, 64'd0);
   endtask

   // Single op into an empty pipe; returns edges until out_valid.
   task automatic lat_test(input int idx, input logic [1:0] o,
                           input logic [63:0] a, input logic [63:0] b,
                           input logic ci, input logic [31:0] lit,
                           input logic lc, input logic lv);
      res_t e;
      int   n;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      op  = o;
      A   = a;
      B   = b;
      cin = ci;
      e   = model(a, b, o, ci, cur_w);
      n   = 0;
      @(posedge clk);
      n++;
      @(negedge clk);
      in_valid = 1'b0;
      while (n < 20) begin
         #1;
         if (m_ov) break;
         @(posedge clk);
         n++;
         @(negedge clk);
      end
      chk("latency", n, cur_s);
      check_outs("dir", e);
      if (cur_w == 32) begin
         chk($sformatf("dir%0d_lit_sum", idx), m_sum, {32'b0, lit});
         chk($sformatf("dir%0d_lit_cv", idx), {62'b0, m_c, m_v},
             {62'b0, lc, lv});
      end
   endtask

   task automatic stream(input int n, input int stall_at);
      int          issued = 0;
      int          done = 0;
      int          cyc = 0;
      int          stalls = 0;
      bit          have = 0;
      bit          snap_ok = 0;
      logic [63:0] sa, sb;
      logic [1:0]  so;
      logic        sc;
      res_t        snap, e;
      q.delete();
      while (done < n && cyc < 300) begin
         out_ready = !(cyc >= stall_at && cyc < stall_at + 3);
         if (!have && issued < n) begin
            sa   = rnd_op();
            sb   = rnd_op();
            so   = 2'($urandom_range(0, 3));
            sc   = 1'($urandom);
            have = 1;
         end
         in_valid = have;
         if (have) begin
            A = sa; B = sb; op = so; cin = sc;
         end else begin
            A = rnd_op(); B = rnd_op();
            op = 2'($urandom_range(0, 3)); cin = 1'($urandom);
         end
         #1;
         if (m_ov && !out_ready) begin
            stalls++;
            chk("stall_iready", {63'b0, m_ir}, 64'd0);
            if (snap_ok) check_outs("stall_hold", snap);
            else begin
               snap.sum = m_sum; snap.c = m_c; snap.v = m_v;
               snap.z = m_z; snap.n = m_n; snap_ok = 1;
            end
         end else snap_ok = 0;
         if (m_ov && out_ready) begin
            if (q.size() == 0) chk("extra_out", 64'd1, 64'd0);
            else begin
               e = q.pop_front();
               check_outs("stream", e);
            end
            done++;
         end
         if (in_valid && m_ir) begin
            q.push_back(model(sa, sb, so, sc, cur_w));
            issued++;
            have = 0;
         end
         @(posedge clk);
         @(negedge clk);
         cyc++;
      end
      chk("stream_done", done, n);
      chk("stream_stalls", stalls, 3);
      chk("stream_cycles", cyc, n + cur_s + 3);
      in_valid  = 1'b0;
      out_ready = 1'b1;
   endtask

   task automatic flight_reset();
      int cnt = 0;
      int seen = 0;
      int want;
      want = (cur_s < 3) ? cur_s : 3;
      out_ready = 1'b0;
      for (int i = 0; i < 6 && cnt < 3; i++) begin
         in_valid = 1'b1;
         A = rnd_op(); B = rnd_op();
         op = 2'($urandom_range(0, 3)); cin = 1'($urandom);
         #1;
         if (m_ir) cnt++;
         @(posedge clk);
         @(negedge clk);
      end
      chk("flight_cnt", cnt, want);
      rst      = 1'b1;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst       = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      #1;
      chk("flight_ovalid", {63'b0, m_ov}, 64'd0);
      chk("flight_sum", m_sum, 64'd0);
      chk("flight_flags", {60'b0, m_c, m_v, m_z, m_n}, 64'd0);
      repeat (12) begin
         @(posedge clk);
         @(negedge clk);
         #1;
         if (m_ov) seen++;
      end
      chk("flight_gone", seen, 0);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      A = '0; B = '0; op = '0; cin = 1'b0;
      sel = 0; cur_w = 32; cur_s = 4;
      for (int p = 0; p < 3; p++) begin
         sel   = p;
         cur_w = (p == 0) ? 32 : 64;
         cur_s = (p == 0) ? 4 : (p == 1) ? 1 : 8;
         @(negedge clk);
         reset_dut();
         lat_test(0, 2'b00, 64'hFFFF_FFFF, 64'd1, 1'b0,
                  32'h0000_0000, 1'b1, 1'b0);
         lat_test(1, 2'b01, 64'h8000_0000, 64'd1, 1'b0,
                  32'h7FFF_FFFF, 1'b1, 1'b1);
         lat_test(2, 2'b01, 64'd5, 64'd7, 1'b0,
                  32'hFFFF_FFFE, 1'b0, 1'b0);
         lat_test(3, 2'b10, 64'h0000_FFFF, 64'd1, 1'b1,
                  32'h0001_0001, 1'b0, 1'b0);
         lat_test(4, 2'b11, 64'h0001_0000, 64'd0, 1'b0,
                  32'h0000_FFFF, 1'b1, 1'b0);
         @(negedge clk);
         stream(8, cur_s + 1);
         stream(24, cur_s + 4);
         flight_reset();
      end
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/pipelined_add_sub.md
# pipelined_add_sub

Parametrised, pipelined two's-complement adder/subtracter with carry-in, status flags and a valid/ready handshake. The WIDTH-bit carry chain is split into STAGES equal chunks, one chunk resolved per pipeline stage, so the datapath scales to wide words without a full-width ripple path in one cycle. It sits in the execute stage of the SimpleRisc datapath as the arithmetic unit for add, sub, cmp and add/sub-with-carry, and feeds result and flags to writeback and the flags register.

## Interface
Parameters:
- WIDTH, 32, operand/result width; must be a multiple of STAGES.
- STAGES, 4, pipeline depth and number of carry-chain chunks; 1..WIDTH. Chunk width CW = WIDTH/STAGES.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands/op present.
- in_ready  out  1  block accepts this cycle.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- op  in  2  00 add (A+B), 01 sub (A-B), 10 adc (A+B+cin), 11 sbc (A-B-!cin; cin=1 means no borrow).
- cin  in  1  carry/not-borrow in; ignored for op 00/01.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- Sum  out  WIDTH  result, modulo 2^WIDTH.
- Cout  out  1  carry out of MSB; for sub/sbc, 1 = no borrow.
- V  out  1  signed overflow.
- Z  out  1  Sum == 0.
- N  out  1  Sum[WIDTH-1].

## Operation
- Effective B: B ^ {WIDTH{op[0]}}. Effective carry-in c0: op=00 → 0, 01 → 1, 10 → cin, 11 → cin.
- Stage k (0..STAGES-1) computes chunk k bits [k*CW +: CW] from A/B' chunk k plus the carry registered from stage k-1 (stage 0 uses c0). Lower result chunks and upper operand chunks travel down the pipeline in registers alongside.
- Final stage registers: Sum, Cout = carry out of bit WIDTH-1, V = carry into bit WIDTH-1 XOR Cout, Z, N. Z and N are computed from the full assembled Sum in the last stage.
- Each stage holds a valid bit. A global advance = out_ready | ~out_valid. When advance=1, every stage shifts forward by one and stage 0 loads the input; when advance=0, all stages hold.
- in_ready = advance. Transfer occurs when in_valid & in_ready. Bubbles are not collapsed during a stall.
- Operations complete in issue order; none are dropped or duplicated.

## Timing
- Reset (rst=1 at a clock edge): all stage valid bits 0; out_valid=0; Sum=0, Cout=V=Z=N=0 on the next cycle. Data in flight is discarded. in_ready reads 1 while out_valid=0. rst takes priority over any transfer in the same cycle.
- Latency: an operation accepted at edge t appears with out_valid=1 after edge t+STAGES-1, i.e. STAGES registered stages. STAGES=1 is a single registered full-width adder.
- Throughput: 1 operation/cycle while out_ready=1.
- Stall: out_valid=1 & out_ready=0 → all outputs and stage contents hold stable; in_ready=0.
- When out_valid=0, the pipeline advances even if out_ready=0, so the pipe fills.
- Same-cycle output consume and input accept is allowed and does not add a bubble.
- Wrap-around: Sum is modulo 2^WIDTH; overflow is reported only through Cout and V, never saturated.
- A change of cin or op while in_valid=0 has no effect.

## Test plan
- WIDTH=32, STAGES=4, op=00, A=0xFFFFFFFF, B=0x00000001 → after 4 cycles: Sum=0x00000000, Cout=1, Z=1, V=0, N=0.
- op=01, A=0x80000000, B=0x00000001 → Sum=0x7FFFFFFF, V=1, Cout=1, N=0; op=01, A=5, B=7 → Sum=0xFFFFFFFE, Cout=0, N=1, V=0.
- Carry across a chunk boundary: op=10, cin=1, A=0x0000FFFF, B=0x00000001 → Sum=0x00010001, Cout=0; op=11, cin=0, A=0x00010000, B=0 → Sum=0x0000FFFF.
- Back-to-back stream of 8 random operations with out_ready held low for 3 cycles mid-stream → in_ready=0 during the stall, outputs stable, and all 8 results correct and in order against a reference model.
- Assert rst with 3 operations in flight → out_valid=0 and all flags 0 on the next cycle; none of the in-flight results ever appear.
- Repeat the random stream at STAGES=1 (latency 1) and STAGES=8 (latency 8) with WIDTH=64 → results match the reference model and latency matches STAGES.
